// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider width, FSM encoding and pipeline pause-vector bits
package div_unit_pkg;

  // Default operand/result width of the EX-stage divider.
  localparam int DIV_WIDTH = 32;

  // Pipeline pause vector: one bit per stage, consumed by the pipeline controller.
  localparam int PAUSE_W   = 6;
  localparam int PAUSE_PC  = 0;
  localparam int PAUSE_IF  = 1;
  localparam int PAUSE_ID  = 2;
  localparam int PAUSE_EX  = 3;
  localparam int PAUSE_MEM = 4;
  localparam int PAUSE_WB  = 5;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while the new quotient bit enters at its LSB.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  // Trial subtract one extra bit wide so the borrow tells us whether the divisor fits.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {2'b00, dvs_i};
    fits    = ~diff[WIDTH+1];
    if (fits) begin
      rem_o = diff[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit div.w/mod.w/div.wu/mod.wu unit with EX stall request (option: DIV_FASTPATH_EN)
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             mod_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             pause_ex_req,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  div_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             mod_q, mod_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] fix_quo, fix_rem;
  logic [WIDTH-1:0] fast_result;
  logic             fast_hit;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Trivial operands can bypass the iteration when the fast path is built in.
`ifdef DIV_FASTPATH_EN
  assign fast_hit = (divisor == '0) || (dividend == '0);
`else
  assign fast_hit = 1'b0;
`endif

  // Operand magnitudes and the fast-path result, derived straight from the EX inputs.
  always_comb begin
    dvd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    if (divisor == '0) begin
      fast_result = mod_op ? dividend : '1;
    end else begin
      fast_result = '0;
    end
  end

  // Sign fix-up of the raw magnitudes; a zero divisor overrides with the architectural results.
  always_comb begin
    fix_quo = qneg_q ? -quo_q : quo_q;
    fix_rem = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    if (dvs_q == '0) begin
      fix_quo = '1;
      fix_rem = dvd_q;
    end
  end

  // A new divide is taken only from IDLE and never in a flush cycle.
  assign accept = (state_q == DIV_IDLE) && start && !cancel;

  // Next-state and datapath-register logic; cancel wins over everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    dvd_d    = dvd_q;
    result_d = result_q;
    mod_d    = mod_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    if (cancel) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            rem_d  = '0;
            quo_d  = dvd_mag;
            dvs_d  = dvs_mag;
            dvd_d  = dividend;
            mod_d  = mod_op;
            qneg_d = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d = signed_op && dividend[WIDTH-1];
            cnt_d  = '0;
            if (fast_hit) begin
              result_d = fast_result;
              state_d  = DIV_DONE;
            end else begin
              state_d  = DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(WIDTH - 1)) begin
            state_d = DIV_FIX;
          end
        end
        DIV_FIX: begin
          result_d = mod_q ? fix_rem : fix_quo;
          state_d  = DIV_DONE;
        end
        DIV_DONE: begin
          // The start still visible here belongs to the retiring instruction.
          state_d = DIV_IDLE;
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      dvd_q    <= '0;
      result_q <= '0;
      mod_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      dvd_q    <= dvd_d;
      result_q <= result_d;
      mod_q    <= mod_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  // Stall is released in the DONE cycle so EX advances together with the result.
  assign pause_ex_req = start && !cancel && !rst && (state_q != DIV_DONE);
  assign done         = (state_q == DIV_DONE) && !cancel && !rst;
  assign result       = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference model
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        mod_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        cancel = 1'b0;
  logic        pause_ex_req;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_op    (signed_op),
    .mod_op       (mod_op),
    .dividend     (dividend),
    .divisor      (divisor),
    .cancel       (cancel),
    .pause_ex_req (pause_ex_req),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic m);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return m ? r : q;
  endfunction

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic m, input bit keep, input string tag);
    int lat, pcount, didx;
    logic [31:0] got, exp;
    lat = 34;
`ifdef DIV_FASTPATH_EN
    if (a == 32'd0 || b == 32'd0) lat = 1;
`endif
    exp = ref_model(a, b, s, m);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    mod_op    = m;
    start     = 1'b1;
    pcount    = 0;
    didx      = -1;
    got       = 'x;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pause_ex_req) pcount++;
      if (done) begin
        didx = i;
        got  = result;
        break;
      end
    end
    chk({tag, "_latency"}, didx, lat);
    chk({tag, "_pause_cycles"}, pcount, lat);
    chk({tag, "_result"}, got, exp);
    @(posedge clk);
    #1;
    if (!keep) begin
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle_pause"}, {31'd0, pause_ex_req}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int sel;

    // Reset: pause must stay low even with start high.
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_pause", {31'd0, pause_ex_req}, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases.
    issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, "divu_100_7");
    issue(32'd100, 32'd7, 1'b0, 1'b1, 1'b0, "modu_100_7");
    issue(-32'sd7, 32'd2, 1'b1, 1'b0, 1'b0, "div_m7_2");
    issue(-32'sd7, 32'd2, 1'b1, 1'b1, 1'b0, "mod_m7_2");
    issue(32'd7, -32'sd2, 1'b1, 1'b1, 1'b0, "mod_7_m2");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "div_ovf");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, "mod_ovf");
    issue(32'd5, 32'd0, 1'b1, 1'b0, 1'b0, "div_by0");
    issue(32'd5, 32'd0, 1'b0, 1'b1, 1'b0, "modu_by0");
    issue(-32'sd9, 32'd0, 1'b1, 1'b1, 1'b0, "mod_neg_by0");

    // Back-to-back: second start seen in IDLE right after DONE.
    issue(32'd1000, 32'd33, 1'b0, 1'b0, 1'b1, "b2b_first");
    issue(32'hFFFF_FF00, 32'd17, 1'b1, 1'b1, 1'b0, "b2b_second");

    // Cancel at T+10, fresh divide at T+12.
    dividend  = 32'd1000;
    divisor   = 32'd3;
    signed_op = 1'b0;
    mod_op    = 1'b0;
    start     = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_pause", {31'd0, pause_ex_req}, 32'd0);
    chk("cancel_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    chk("post_cancel_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    issue(32'd12345, 32'd10, 1'b0, 1'b1, 1'b0, "after_cancel");

    // Reset asserted mid-CALC with a nonzero result still held.
    dividend  = 32'd99999;
    divisor   = 32'd7;
    signed_op = 1'b0;
    mod_op    = 1'b0;
    start     = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pause_same", {31'd0, pause_ex_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_pause", {31'd0, pause_ex_req}, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    issue(32'd99999, 32'd7, 1'b0, 1'b0, 1'b0, "after_reset");

    // Randomized operands, ops and back-to-back spacing.
    for (int n = 0; n < 24; n++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4:       begin ra = 32'd0; rb = $urandom; end
        5:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (n != 23) && ($urandom_range(0, 1) == 1), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider in the EX stage, and the source of the `pause_ex` stall request consumed by the pipeline controller. It executes LoongArch `div.w`, `mod.w`, `div.wu` and `mod.wu` with a radix-2 restoring algorithm. While a division is in flight it holds the EX stage and everything upstream stalled. It releases the stall in the same cycle it presents the result.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  divide instruction present in EX. Held high for as long as the instruction sits in EX.
- `signed_op`  input  1  1 selects `div.w`/`mod.w`; 0 selects the unsigned forms.
- `mod_op`  input  1  1 returns the remainder; 0 returns the quotient.
- `dividend`  input  WIDTH  rj operand, stable while `start` is high.
- `divisor`  input  WIDTH  rk operand, stable while `start` is high.
- `cancel`  input  1  pipeline flush (exception or branch).
- `pause_ex_req`  output  1  combinational stall request to the controller.
- `done`  output  1  result valid for exactly one cycle.
- `result`  output  WIDTH  quotient or remainder, valid only when `done` is high.

## Operation
- States are IDLE, CALC, FIX and DONE.
- **IDLE:**
  - On `start & ~cancel`, latch the operand magnitudes, `signed_op`, `mod_op`, the sign of the quotient (signed & sign(dividend) ^ sign(divisor)) and the sign of the remainder (signed & sign(dividend)).
  - Clear the 6-bit iteration counter and go to CALC.
- **CALC:** perform one restoring step per cycle on a WIDTH+1-bit partial remainder, shifting in one quotient bit. After the 32nd step (counter == 31), go to FIX.
- **FIX:** apply two's-complement negation to the quotient and/or remainder per the latched signs, select the output per `mod_op`, register `result`, then go to DONE.
- **DONE:** `done = 1` for one cycle, then return to IDLE. A `start` seen in DONE is the retiring instruction and must not restart the divider.
- `pause_ex_req = start & ~cancel & (state != DONE)`. This covers the IDLE cycle in which `start` first appears.
- **Divisor zero:** quotient = 0xFFFFFFFF and remainder = raw dividend, for both signed and unsigned forms.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. This falls out of the magnitude arithmetic and needs no special case.
- **Cancel:** in any state, go to IDLE on the next edge, with `done` not asserted and `pause_ex_req` low in that cycle. A `start` in the same cycle as `cancel` is ignored.
- **Reset:** state goes to IDLE; `done`, `result`, the counter and all latched operands go to 0. `pause_ex_req` is 0 while `rst` is high.

## Timing
- `start` rises in cycle T (IDLE):
  - CALC occupies T+1 to T+32.
  - FIX occupies T+33.
  - DONE occupies T+34.
- `pause_ex_req` is high from T to T+33 and low at T+34, so EX advances on the T+34 edge with `result` valid. Total EX occupancy is 35 cycles.
- Back-to-back divides: the next instruction's `start` is seen in IDLE at T+35, giving 35 cycles each with no dead cycle beyond the DONE handoff.
- Whenever `start` is low, `pause_ex_req` is low regardless of state.

## Configuration
- `DIV_FASTPATH_EN`
  - **Defined:** when IDLE sees divisor == 0 or dividend == 0, the divider skips CALC and FIX, loads the final `result` directly and enters DONE at T+1. `pause_ex_req` is high only in cycle T.
  - **Undefined:** these cases take the full 35 cycles. The divisor-zero results are forced in FIX.
  - Results are identical in both builds.

## Structure
- The state encodings and the `WIDTH` default go in the shared define file, alongside the existing pause-vector constants.
- One sub-module, `div_step`: a combinational single restoring step that takes {partial remainder, quotient, divisor} and returns the next pair. The FSM, the counter and the sign fix stay in `div_unit`.

## Test plan
- **Unsigned divide:** `div.wu` 100 / 7 → `result` = 14 at T+34, `pause_ex_req` high for exactly 34 cycles. `mod.wu` with the same operands → 2.
- **Signed divide:** `div.w` −7 / 2 → 0xFFFFFFFD (−3). `mod.w` −7 / 2 → 0xFFFFFFFF (−1). `mod.w` 7 / −2 → 1.
- **Overflow:** `div.w` 0x80000000 / 0xFFFFFFFF → 0x80000000. `mod.w` with the same operands → 0.
- **Divide by zero:** `div.w` 5 / 0 → 0xFFFFFFFF and `mod.wu` 5 / 0 → 5. Done at T+34, or at T+1 with `DIV_FASTPATH_EN`.
- **Cancel:** `cancel` pulsed at T+10 → IDLE at T+11, no `done`. A new `start` at T+12 gives a correct result at T+46.
- **Back-to-back and reset:** two consecutive divides each complete in 35 cycles with no duplicate `done`. `rst` asserted mid-CALC → `done` = 0, `result` = 0 and `pause_ex_req` = 0 on the next cycle.
